instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction-side counterpart of the program counter: takes the current pc, reads the instruction word from instruction memory over a req/ready/rvalid handshake, and holds it in the instruction register.
- Decodes the fields the pc, register file and ALU consume: opcode, func3, rd, rs1, rs2.
- Sits between the program counter and the instruction memory port. Driven one fetch at a time by the multi-cycle control FSM.

Parameters:
- MAX_WAIT, 16: edges allowed from fetch accept to completion before timeout; legal range 2..255.
- NOP_WORD, 32'h0000_0013: value loaded into the instruction register on reset and on any fetch error (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pc  input  32  fetch address from the program counter
- fetch_start  input  1  single-cycle request from control FSM to fetch at pc
- mem_req  output  1  read request to instruction memory (registered)
- mem_addr  output  32  read address, held stable while mem_req=1 (registered)
- mem_ready  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  mem_rdata valid this cycle
- mem_rdata  input  32  instruction word from memory
- instr  output  32  instruction register
- opcode  output  7  instr[6:0]
- func3  output  3  instr[14:12]
- rd  output  5  instr[11:7]
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]
- instr_valid  output  1  instr holds a successfully fetched word
- busy  output  1  fetch in progress; state != IDLE, combinational
- fetch_err  output  1  last fetch failed: misaligned or timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mem_req=0, mem_addr=0, instr=NOP_WORD, instr_valid=0, fetch_err=0, wait counter=0.
  - Applies immediately, including mid-fetch. Any outstanding memory response is discarded.
- Decoded fields are combinational slices of instr only; they never change while instr is unchanged.
- State IDLE:
  - fetch_start=1 and pc[1:0]==0: mem_addr<=pc, mem_req<=1, instr_valid<=0, fetch_err<=0, counter<=0, go to REQ.
  - fetch_start=1 and pc[1:0]!=0: fetch_err<=1, instr<=NOP_WORD, instr_valid<=0, stay in IDLE. No memory request is issued.
  - mem_ready and mem_rvalid are ignored in IDLE.
- State REQ (mem_req=1, mem_addr stable):
  - mem_ready=1, mem_rvalid=0: mem_req<=0, go to WAIT.
  - mem_ready=1, mem_rvalid=1 (zero-wait memory): instr<=mem_rdata, instr_valid<=1, mem_req<=0, go to IDLE.
  - mem_ready=0: hold.
- State WAIT:
  - mem_rvalid=1: instr<=mem_rdata, instr_valid<=1, go to IDLE.
- Counter:
  - Increments on every edge spent in REQ or WAIT without completion.
  - At the edge where counter==MAX_WAIT-1 and no completion occurs: timeout. mem_req<=0, instr<=NOP_WORD, instr_valid<=0, fetch_err<=1, go to IDLE.
  - Completion on that same edge wins over timeout.
- fetch_start while busy=1 is ignored; no queuing.
- instr_valid and fetch_err are level outputs, held until the next accepted fetch_start.
- Nominal latency: fetch_start at edge E0, mem_ready at E1, mem_rvalid at E2 -> instr_valid=1 after E2. Zero-wait case completes after E1.
- mem_addr is not incremented or modified; pc arithmetic belongs to the program counter.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> instr=32'h0000_0013, opcode=7'b0010011, instr_valid=0, busy=0, mem_req=0.
- Normal fetch: pc=32'h0000_0040, fetch_start pulse, mem_ready at next cycle, mem_rvalid with rdata=32'h00A28263 one cycle later -> mem_addr=0x40 while mem_req=1; instr=0x00A28263; opcode=1100011, func3=000, rs1=5, rs2=10; instr_valid=1 three edges after start.
- Zero-wait plus ready stall: mem_ready low 4 cycles, then mem_ready and mem_rvalid high together with rdata=32'h000000E7 -> mem_addr held stable for all 5 cycles; instr=0xE7 (opcode=1100111); busy drops the same edge.
- Misaligned: pc=32'h0000_0042, fetch_start -> mem_req stays 0, fetch_err=1, instr=NOP_WORD; next fetch_start at pc=0x44 clears fetch_err.
- Timeout: MAX_WAIT=16, mem_ready=1, mem_rvalid never asserted -> fetch_err=1 and busy=0 exactly 16 edges after fetch accept; instr=NOP_WORD; a late mem_rvalid in IDLE is ignored.
- Reset mid-fetch and ignored start: fetch_start again while in WAIT -> no effect; assert rst_n=0 in WAIT -> busy=0 and mem_req=0 immediately, and mem_rvalid after release leaves instr=NOP_WORD.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: registered request/address from the fetch
// unit, ready/rvalid/rdata returned by the memory.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Fetch unit side: issues the request, consumes the response.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    // Memory side: accepts the request, returns the instruction word.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word at pc over a req/ready/rvalid
// handshake, holds it in the instruction register and exposes the decoded
// register/opcode fields. Misaligned pc and response timeout load a NOP and
// raise fetch_err.
module instr_fetch_unit #(
    parameter int          MAX_WAIT = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                pc,
    input  logic                       fetch_start,
    instr_fetch_unit_if.master         mem,
    output logic [31:0]                instr,
    output logic [6:0]                 opcode,
    output logic [2:0]                 func3,
    output logic [4:0]                 rd,
    output logic [4:0]                 rs1,
    output logic [4:0]                 rs2,
    output logic                       instr_valid,
    output logic                       busy,
    output logic                       fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Counter value at which the next edge without completion is a timeout.
    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_reg;
    logic        mem_req_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] instr_reg;
    logic        instr_valid_reg;
    logic        fetch_err_reg;
    logic [7:0]  wait_cnt_reg;

    // Fetch sequencing: request issue, response capture, timeout and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= 32'd0;
            instr_reg       <= NOP_WORD;
            instr_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            wait_cnt_reg    <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Responses arriving here belong to no fetch and are dropped.
                    if (fetch_start) begin
                        if (pc[1:0] == 2'b00) begin
                            mem_addr_reg    <= pc;
                            mem_req_reg     <= 1'b1;
                            instr_valid_reg <= 1'b0;
                            fetch_err_reg   <= 1'b0;
                            wait_cnt_reg    <= 8'd0;
                            state_reg       <= REQ;
                        end else begin
                            // Misaligned: fail locally, never touch memory.
                            fetch_err_reg   <= 1'b1;
                            instr_reg       <= NOP_WORD;
                            instr_valid_reg <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ready && mem.mem_rvalid) begin
                        // Zero-wait memory: accept and data on the same edge.
                        instr_reg       <= mem.mem_rdata;
                        instr_valid_reg <= 1'b1;
                        mem_req_reg     <= 1'b0;
                        state_reg       <= IDLE;
                    end else if (wait_cnt_reg == LAST_CNT) begin
                        mem_req_reg     <= 1'b0;
                        instr_reg       <= NOP_WORD;
                        instr_valid_reg <= 1'b0;
                        fetch_err_reg   <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (mem.mem_ready) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        instr_reg       <= mem.mem_rdata;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else if (wait_cnt_reg == LAST_CNT) begin
                        instr_reg       <= NOP_WORD;
                        instr_valid_reg <= 1'b0;
                        fetch_err_reg   <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_reg;
    assign mem.mem_addr = mem_addr_reg;

    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign fetch_err   = fetch_err_reg;
    assign busy        = (state_reg != IDLE);

    // Field decode is a pure slice of the instruction register.
    assign opcode = instr_reg[6:0];
    assign rd     = instr_reg[11:7];
    assign func3  = instr_reg[14:12];
    assign rs1    = instr_reg[19:15];
    assign rs2    = instr_reg[24:20];

endmodule
